// File: rtl/hlsm_sched_dp_pkg.sv
// Shared types and constants for the scheduled HLS test datapath.
// State counter encoding, phase decode and legal parameter bounds.
package hlsm_sched_dp_pkg;

  localparam int MIN_LATENCY = 3;
  localparam int MAX_LATENCY = 16;
  localparam int ST_W        = 5;

  typedef logic [ST_W-1:0] st_t;

  localparam st_t ST_WAIT = st_t'(0);
  localparam st_t S_BASE  = st_t'(1);

  typedef enum logic [2:0] {
    PH_WAIT,
    PH_S1,
    PH_S2,
    PH_S3,
    PH_PAD,
    PH_FINAL
  } phase_e;

  function automatic st_t st_final(input int lat);
    return st_t'(lat + 1);
  endfunction

  // FINAL is always above S3 since LATENCY >= 3
  function automatic phase_e st_phase(input st_t s, input st_t fin);
    phase_e p;
    p = PH_PAD;
    unique case (1'b1)
      (s == ST_WAIT):          p = PH_WAIT;
      (s == fin):              p = PH_FINAL;
      (s == S_BASE):           p = PH_S1;
      (s == st_t'(2)):         p = PH_S2;
      (s == st_t'(3)):         p = PH_S3;
      default:                 p = PH_PAD;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/hlsm_sched_dp_mul.sv
// Signed truncating multiplier: keeps the DATAWIDTH LSBs of the product.
// The low half of a product is identical for signed and unsigned operands.
module hls_mul #(
  parameter int DATAWIDTH = 16
) (
  input  logic signed [DATAWIDTH-1:0] a_i,
  input  logic signed [DATAWIDTH-1:0] b_i,
  output logic signed [DATAWIDTH-1:0] y_o
);

  assign y_o = a_i * b_i;

endmodule

// File: rtl/hlsm_sched_dp.sv
// FSM-scheduled datapath: j = (a*b + c)*d, k = e*f.
// Binary state counter WAIT, S1..S_L, FINAL; Done is registered from FINAL.
module hlsm_sched_dp
  import hlsm_sched_dp_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int LATENCY   = 4,
  parameter int NUM_MULT  = 2
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Start,
  input  logic signed [DATAWIDTH-1:0] a,
  input  logic signed [DATAWIDTH-1:0] b,
  input  logic signed [DATAWIDTH-1:0] c,
  input  logic signed [DATAWIDTH-1:0] d,
  input  logic signed [DATAWIDTH-1:0] e,
  input  logic signed [DATAWIDTH-1:0] f,
  output logic                        Done,
  output logic signed [DATAWIDTH-1:0] j,
  output logic signed [DATAWIDTH-1:0] k
);

  typedef logic signed [DATAWIDTH-1:0] word_t;

  localparam st_t ST_FIN = st_final(LATENCY);

  generate
    if (LATENCY < MIN_LATENCY || LATENCY > MAX_LATENCY ||
        (NUM_MULT != 1 && NUM_MULT != 2)) begin : g_bad_cfg
      $error("hlsm_sched_dp: illegal LATENCY or NUM_MULT");
    end
  endgenerate

  st_t    st_q, st_d;
  phase_e ph;
  logic   accept;

  word_t a_q, b_q, c_q, d_q, e_q, f_q;
  word_t h_q, i_q, j_q, k_q;
  logic  done_q;

  word_t m0_a, m0_b, m0_y, m1_y;
  logic  k_we;

  assign ph     = st_phase(st_q, ST_FIN);
  assign accept = (ph == PH_WAIT) && Start;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      st_q <= ST_WAIT;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (ph)
      PH_WAIT:  if (Start) st_d = S_BASE;
      PH_FINAL: st_d = ST_WAIT;
      default:  st_d = st_q + st_t'(1);
    endcase
  end

  // Multiplier 0 serves a*b in S1 and i*d in S3; when it is the
  // only one, it also serves e*f in the otherwise free S2 slot.
  always_comb begin
    m0_a = a_q;
    m0_b = b_q;
    unique case (1'b1)
      (ph == PH_S3): begin
        m0_a = i_q;
        m0_b = d_q;
      end
      (NUM_MULT == 1 && ph == PH_S2): begin
        m0_a = e_q;
        m0_b = f_q;
      end
      default: ;
    endcase
  end

  hls_mul #(.DATAWIDTH(DATAWIDTH)) u_mul0 (
    .a_i (m0_a),
    .b_i (m0_b),
    .y_o (m0_y)
  );

  generate
    if (NUM_MULT == 2) begin : g_two_mul
      hls_mul #(.DATAWIDTH(DATAWIDTH)) u_mul1 (
        .a_i (e_q),
        .b_i (f_q),
        .y_o (m1_y)
      );
      assign k_we = (ph == PH_S1);
    end else begin : g_one_mul
      assign m1_y = m0_y;
      assign k_we = (ph == PH_S2);
    end
  endgenerate

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      e_q    <= '0;
      f_q    <= '0;
      h_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      done_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= a;
        b_q <= b;
        c_q <= c;
        d_q <= d;
        e_q <= e;
        f_q <= f;
      end
      if (ph == PH_S1) h_q <= m0_y;
      if (ph == PH_S2) i_q <= h_q + c_q;
      if (ph == PH_S3) j_q <= m0_y;
      if (k_we)        k_q <= m1_y;
      done_q <= (ph == PH_FINAL);
    end
  end

  assign Done = done_q;
  assign j    = j_q;
  assign k    = k_q;

endmodule

// File: tb/tb_hlsm_sched_dp.sv
// Scoreboard bench for hlsm_sched_dp across three LATENCY/NUM_MULT builds.
// Stimulus pushes expected results; a negedge monitor pops on Done.
module tb_hlsm_sched_dp;

  localparam int N = 3;
  localparam int LAT [N] = '{4, 6, 3};

  typedef struct {
    logic signed [15:0] j;
    logic signed [15:0] k;
    int                 edge_no;
  } exp_t;

  logic clk;
  logic rst;
  logic start;
  logic signed [15:0] a, b, c, d, e, f;
  logic               done [N];
  logic signed [15:0] jo [N];
  logic signed [15:0] ko [N];

  exp_t q [N][$];
  int   cyc;
  int   ncmp;
  int   nerr;

  hlsm_sched_dp #(.DATAWIDTH(16), .LATENCY(4), .NUM_MULT(2)) u_dut0 (
    .Clk(clk), .Rst(rst), .Start(start),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .Done(done[0]), .j(jo[0]), .k(ko[0])
  );

  hlsm_sched_dp #(.DATAWIDTH(16), .LATENCY(6), .NUM_MULT(1)) u_dut1 (
    .Clk(clk), .Rst(rst), .Start(start),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .Done(done[1]), .j(jo[1]), .k(ko[1])
  );

  hlsm_sched_dp #(.DATAWIDTH(16), .LATENCY(3), .NUM_MULT(1)) u_dut2 (
    .Clk(clk), .Rst(rst), .Start(start),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f),
    .Done(done[2]), .j(jo[2]), .k(ko[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int idx,
                     input longint act, input longint exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %0d want %0d", nm, idx, act, exp);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          if (q[i].size() == 0) begin
            chk("spurious_done", i, 1, 0);
          end else begin
            exp_t x;
            x = q[i].pop_front();
            chk("j", i, jo[i], x.j);
            chk("k", i, ko[i], x.k);
            chk("done_edge", i, cyc, x.edge_no);
          end
        end
      end
    end
  end

  task automatic set_ops(input int va, vb, vc, vd, ve, vf);
    a = 16'(va);
    b = 16'(vb);
    c = 16'(vc);
    d = 16'(vd);
    e = 16'(ve);
    f = 16'(vf);
  endtask

  // Call at a negedge: present a request for one edge
  task automatic go(input int va, vb, vc, vd, ve, vf,
                    input int ej, ek, input bit push);
    exp_t x;
    set_ops(va, vb, vc, vd, ve, vf);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      for (int i = 0; i < N; i++) begin
        x.j       = 16'(ej);
        x.k       = 16'(ek);
        x.edge_no = cyc + LAT[i] + 1;
        q[i].push_back(x);
      end
    end
  endtask

  task automatic idle();
    repeat (10) @(negedge clk);
  endtask

  initial begin
    exp_t x;
    int   acc;
    ncmp  = 0;
    nerr  = 0;
    rst   = 1'b1;
    start = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk("rst_done", i, done[i], 0);
      chk("rst_j", i, jo[i], 0);
      chk("rst_k", i, ko[i], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    go(3, 4, 5, 2, -6, 7, 34, -42, 1'b1);
    idle();

    go(300, 300, 0, 1, 256, 256, 24464, 0, 1'b1);
    idle();

    // Operands and Start changed while in S2 must be ignored
    go(1, 2, 3, 4, 5, 6, 20, 30, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_ops(3, 4, 5, 2, -6, 7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    set_ops(9, 9, 9, 9, 9, 9);
    idle();

    // Reset in S2 aborts; outputs clear without a clock edge
    go(3, 4, 5, 2, -6, 7, 0, 0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < N; i++) q[i].delete();
    #1;
    for (int i = 0; i < N; i++) begin
      chk("async_done", i, done[i], 0);
      chk("async_j", i, jo[i], 0);
      chk("async_k", i, ko[i], 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    go(3, 4, 5, 2, -6, 7, 34, -42, 1'b1);
    idle();

    go(-5, 7, -3, -2, -8, -9, 76, 72, 1'b1);
    idle();

    // Start held high: one accept every LATENCY+2 edges
    set_ops(300, 300, 0, 1, 256, 256);
    start = 1'b1;
    acc = cyc + 1;
    for (int i = 0; i < N; i++) begin
      for (int n = 0; n * (LAT[i] + 2) <= 23; n++) begin
        x.j       = 16'sd24464;
        x.k       = 16'sd0;
        x.edge_no = acc + n * (LAT[i] + 2) + LAT[i] + 1;
        q[i].push_back(x);
      end
    end
    repeat (24) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (12) @(negedge clk);

    for (int i = 0; i < N; i++) begin
      chk("pending_done", i, q[i].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
